// File: rtl/core_sequencer_pkg.sv
// Shared types and opcode decode for the core array instruction sequencer.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package core_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_STALL
    } seq_state_t;

    localparam logic [1:0]  OP_MISC        = 2'b11;
    localparam int          OUT_BIT_POS    = 4;
    localparam logic [15:0] DEF_END_OPCODE = 16'hFFFF;

    // Output instructions make the core array present one result bit afterwards.
    function automatic logic is_output_op(input logic [15:0] op);
        return (op[15:14] == OP_MISC) && op[OUT_BIT_POS];
    endfunction

endpackage

// File: rtl/core_sequencer_pixel_packer.sv
// Packs core array output bits, first bit in MSB, into pixel words.
// Latency: bit sampled 1 cycle after an output-op execute; word valid the cycle after its last bit.
// Backpressure: single holding register; full_next tells the issuer the next output op would overflow it.
module pixel_packer #(
    parameter int PIXEL_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  cap_req,
    input  logic                  core_out_bit,
    input  logic                  pixel_ready,
    output logic [PIXEL_BITS-1:0] pixel_data,
    output logic                  pixel_valid,
    output logic                  full_next
);

    localparam int              CNT_W = $clog2(PIXEL_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXEL_BITS - 1);

    logic [PIXEL_BITS-1:0] shift_q;
    logic [PIXEL_BITS-1:0] shift_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_eff;
    logic                  capture_pending;
    logic                  word_done;

    assign shift_nxt = {shift_q[PIXEL_BITS-2:0], core_out_bit};
    assign word_done = capture_pending && !clear && (bit_cnt == LAST);

    // A capture may still be in flight when the next op is evaluated; count it.
    assign cnt_eff   = bit_cnt + CNT_W'(capture_pending);
    assign full_next = (cnt_eff == LAST) && pixel_valid && !pixel_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q         <= '0;
            bit_cnt         <= '0;
            capture_pending <= 1'b0;
            pixel_data      <= '0;
            pixel_valid     <= 1'b0;
        end else begin
            capture_pending <= cap_req && !clear;
            if (clear || word_done) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (capture_pending) begin
                shift_q <= shift_nxt;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (word_done) begin
                pixel_data  <= shift_nxt;
                pixel_valid <= 1'b1;
            end else if (pixel_valid && pixel_ready) begin
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Fetches opcodes from program memory and issues them to the core array, packing output bits into pixels.
// Latency: 2 cycles per instruction (fetch, issue); optional step input when CORE_SEQUENCER_STEP_EN is defined.
// Backpressure: holds an output op in STALL while its bit would complete a word the pixel consumer cannot take.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter int          PIXEL_BITS = 6,
    parameter logic [15:0] END_OPCODE = DEF_END_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop_en,
`ifdef CORE_SEQUENCER_STEP_EN
    input  logic                  step,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     prog_addr,
    input  logic [15:0]           prog_data,
    output logic [15:0]           opcode,
    output logic                  execute,
    input  logic                  core_out_bit,
    output logic [PIXEL_BITS-1:0] pixel_data,
    output logic                  pixel_valid,
    input  logic                  pixel_ready
);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       op_hold;
    logic [15:0]       issue_op;
    logic              issue_now;
    logic              full_next;
    logic              step_ok;

`ifdef CORE_SEQUENCER_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    always_comb begin
        issue_op  = (state == ST_STALL) ? op_hold : prog_data;
        issue_now = 1'b0;
        if (!abort) begin
            if (state == ST_ISSUE)
                issue_now = (prog_data != END_OPCODE) && step_ok &&
                            !(is_output_op(prog_data) && full_next);
            else if (state == ST_STALL)
                issue_now = !full_next;
        end
    end

    // prog_addr moves together with pc so memory data is ready by ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            prog_addr <= '0;
            opcode    <= '0;
            op_hold   <= '0;
            execute   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            execute <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                pc    <= '0;
            end else if (issue_now) begin
                opcode    <= issue_op;
                execute   <= 1'b1;
                pc        <= pc + ADDR_W'(1);
                prog_addr <= pc + ADDR_W'(1);
                state     <= ST_FETCH;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        pc        <= '0;
                        prog_addr <= '0;
                        busy      <= 1'b1;
                        state     <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        prog_addr <= pc;
                        state     <= ST_ISSUE;
                    end
                    ST_ISSUE: if (prog_data == END_OPCODE) begin
                        if (loop_en) begin
                            pc        <= '0;
                            prog_addr <= '0;
                            state     <= ST_FETCH;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (step_ok) begin
                        // Not issued despite step: stalled on the pixel path.
                        op_hold <= prog_data;
                        state   <= ST_STALL;
                    end
                    ST_STALL: state <= ST_STALL;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    pixel_packer #(.PIXEL_BITS(PIXEL_BITS)) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (abort),
        .cap_req      (execute && is_output_op(opcode)),
        .core_out_bit (core_out_bit),
        .pixel_ready  (pixel_ready),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .full_next    (full_next)
    );

endmodule
